namco_io56xx: RTL and testbench

Cycle-level model of the Namco 56XX custom I/O chip pair, sitting beside the main CPU at $4800-$4FFF. Holds a 2×16-nibble register file. On each VBLANK rising edge it runs the mode written by the CPU: coin/credit bookkeeping, joystick and button formatting, or raw DIP-switch readout. It also decodes the MOTOS signature.

---
 rtl/namco_io_pkg.sv | 36 +++
 rtl/namco_io_credit.sv | 58 +++++
 rtl/namco_io56xx.sv | 133 +++++++++++++
 tb/tb_namco_io56xx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/namco_io_pkg.sv
// Shared constants, FSM state type and BCD helper for the Namco 56XX I/O model.
// Build option: NAMCO_IO_CREDIT_EN enables the mode-1 credit counter.
package namco_io_pkg;

  localparam logic [3:0] MODE_CREDIT = 4'h1;
  localparam logic [3:0] MODE_RAW    = 4'h3;
  localparam logic [3:0] MODE_MOTOS0 = 4'h5;
  localparam logic [3:0] MODE_MOTOS1 = 4'h7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CREDIT,
    ST_FORMAT
  } io_state_e;

  localparam int NIB_TENS    = 0;
  localparam int NIB_UNITS   = 1;
  localparam int NIB_FLAGS   = 2;
  localparam int NIB_P1_DIR  = 4;
  localparam int NIB_P1_BTN  = 5;
  localparam int NIB_P2_DIR  = 6;
  localparam int NIB_P2_BTN  = 7;
  localparam int NIB_MODE    = 8;
  localparam int CHIP1_BASE  = 16;
  localparam int DSW_NIBBLES = 6;

  function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 7'd10);
    units = 4'(v % 7'd10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/namco_io_credit.sv
// Credit counter (0..MAX_CREDIT, presented as BCD) with saturating coin add,
// conditional start subtract and per-frame start-accept flags.
module namco_io_credit
  import namco_io_pkg::*;
#(
  parameter int MAX_CREDIT = 99
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       tick_i,
  input  logic       en_i,
  input  logic       coin_i,
  input  logic       start1_i,
  input  logic       start2_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic [1:0] accept_o
);

  logic [6:0] count_q, count_d, after_coin;
  logic [1:0] accept_q, accept_d;

  // Coin is credited first, so a coin and a start in one frame can play;
  // Start1 takes the frame even when it cannot be accepted.
  always_comb begin
    after_coin = count_q;
    if (coin_i && (count_q < 7'(MAX_CREDIT))) after_coin = count_q + 7'd1;
    count_d  = after_coin;
    accept_d = 2'b00;
    if (start1_i) begin
      if (after_coin >= 7'd1) begin
        count_d  = after_coin - 7'd1;
        accept_d = 2'b01;
      end
    end else if (start2_i && (after_coin >= 7'd2)) begin
      count_d  = after_coin - 7'd2;
      accept_d = 2'b10;
    end
    if (!en_i) begin
      count_d  = count_q;
      accept_d = 2'b00;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q  <= 7'd0;
      accept_q <= 2'b00;
    end else if (tick_i) begin
      count_q  <= count_d;
      accept_q <= accept_d;
    end
  end

  assign {tens_o, units_o} = bin_to_bcd(count_q);
  assign accept_o          = accept_q;

endmodule

// File: rtl/namco_io56xx.sv
// Namco 56XX I/O chip pair: 2x16-nibble register file, VBLANK-driven formatter.
// Build option: NAMCO_IO_CREDIT_EN builds the mode-1 credit logic (else mode 1 = mode 3).
module namco_io56xx
  import namco_io_pkg::*;
#(
  parameter int MAX_CREDIT = 99
) (
  input  logic        CPUCLKx2,
  input  logic        RESET_N,
  input  logic        VBLANK,
  input  logic        IO_HOLD,
  input  logic        CS,
  input  logic        WE,
  input  logic [5:0]  AD,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  input  logic [11:0] INP,
  input  logic [2:0]  INP2,
  input  logic [23:0] DSW,
  output logic        IS_MOTOS
);

  io_state_e   state_q;
  logic        vblank_q;
  logic [11:0] inp_q;
  logic [2:0]  inp2_q;
  logic [23:0] dsw_q;
  logic [3:0]  regs_q [0:31];
  logic [3:0]  regs_d [0:31];
  logic [3:0]  mode0, mode1;
  logic        fmt_we, credit_mode0, raw_mode0;
  logic        unused_ok;

  assign mode0  = regs_q[NIB_MODE];
  assign mode1  = regs_q[CHIP1_BASE + NIB_MODE];
  assign fmt_we = (state_q == ST_FORMAT) && !IO_HOLD;

`ifdef NAMCO_IO_CREDIT_EN
  logic [2:0] inp2_prev_q;
  logic [3:0] credit_tens, credit_units;
  logic [1:0] accept;

  assign credit_mode0 = (mode0 == MODE_CREDIT);
  assign raw_mode0    = (mode0 == MODE_RAW);

  // Edges are frame-to-frame: the previous SAMPLE, not the previous clock.
  namco_io_credit #(.MAX_CREDIT(MAX_CREDIT)) u_credit (
    .clk_i    (CPUCLKx2),
    .rst_n_i  (RESET_N),
    .tick_i   ((state_q == ST_CREDIT) && !IO_HOLD),
    .en_i     (credit_mode0),
    .coin_i   (inp2_q[2] && !inp2_prev_q[2]),
    .start1_i (inp2_q[0] && !inp2_prev_q[0]),
    .start2_i (inp2_q[1] && !inp2_prev_q[1]),
    .tens_o   (credit_tens),
    .units_o  (credit_units),
    .accept_o (accept)
  );
`else
  logic [6:0] unused_max;
  assign unused_max   = 7'(MAX_CREDIT);
  assign credit_mode0 = 1'b0;
  assign raw_mode0    = (mode0 == MODE_RAW) || (mode0 == MODE_CREDIT);
`endif

  always_ff @(posedge CPUCLKx2 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      vblank_q    <= 1'b0;
      inp_q       <= '0;
      inp2_q      <= '0;
      dsw_q       <= '0;
`ifdef NAMCO_IO_CREDIT_EN
      inp2_prev_q <= '0;
`endif
    end else begin
      vblank_q <= VBLANK;
      if (IO_HOLD) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE:   if (VBLANK && !vblank_q) state_q <= ST_SAMPLE;
          ST_SAMPLE: begin
            inp_q       <= INP;
            inp2_q      <= INP2;
            dsw_q       <= DSW;
`ifdef NAMCO_IO_CREDIT_EN
            inp2_prev_q <= inp2_q;
`endif
            state_q     <= ST_CREDIT;
          end
          ST_CREDIT: state_q <= ST_FORMAT;
          default:   state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // The CPU write is applied last so it overrides a same-cycle FORMAT write.
  always_comb begin
    regs_d = regs_q;
    if (fmt_we) begin
      if (raw_mode0 || credit_mode0) begin
        regs_d[NIB_P1_DIR] = inp_q[3:0];
        regs_d[NIB_P1_BTN] = {2'b00, inp_q[5:4]};
        regs_d[NIB_P2_DIR] = inp_q[9:6];
        regs_d[NIB_P2_BTN] = {2'b00, inp_q[11:10]};
      end
      if (raw_mode0) regs_d[NIB_TENS] = {1'b0, inp2_q};
`ifdef NAMCO_IO_CREDIT_EN
      if (credit_mode0) begin
        regs_d[NIB_TENS]  = credit_tens;
        regs_d[NIB_UNITS] = credit_units;
        regs_d[NIB_FLAGS] = {2'b00, accept};
      end
`endif
      if (mode1 != 4'h0) begin
        for (int k = 0; k < DSW_NIBBLES; k++) regs_d[CHIP1_BASE + k] = dsw_q[4*k +: 4];
      end
    end
    if (CS && WE) regs_d[AD[4:0]] = DI[3:0];
  end

  always_ff @(posedge CPUCLKx2 or negedge RESET_N) begin
    if (!RESET_N) regs_q <= '{default: 4'h0};
    else          regs_q <= regs_d;
  end

  assign DO        = {4'h0, regs_q[AD[4:0]]};
  assign IS_MOTOS  = (mode0 == MODE_MOTOS0) && (mode1 == MODE_MOTOS1);
  assign unused_ok = &{1'b0, AD[5], DI[7:4]};

endmodule

// File: tb/tb_namco_io56xx.sv
// Self-checking bench for namco_io56xx against a frame-level behavioural model.
// Follows NAMCO_IO_CREDIT_EN the same way the design does.
module tb_namco_io56xx;

  logic        CPUCLKx2 = 1'b0;
  logic        RESET_N, VBLANK, IO_HOLD, CS, WE, IS_MOTOS;
  logic [5:0]  AD;
  logic [7:0]  DI, DO;
  logic [11:0] INP;
  logic [2:0]  INP2;
  logic [23:0] DSW;

  int compared   = 0;
  int mismatched = 0;

  localparam int MAXC = 99;
`ifdef NAMCO_IO_CREDIT_EN
  localparam bit CREDIT_EN = 1'b1;
`else
  localparam bit CREDIT_EN = 1'b0;
`endif

  logic [3:0] mdl [32];
  int         credits;
  logic [2:0] prevIn2;

  namco_io56xx #(.MAX_CREDIT(MAXC)) dut (
    .CPUCLKx2 (CPUCLKx2),
    .RESET_N  (RESET_N),
    .VBLANK   (VBLANK),
    .IO_HOLD  (IO_HOLD),
    .CS       (CS),
    .WE       (WE),
    .AD       (AD),
    .DI       (DI),
    .DO       (DO),
    .INP      (INP),
    .INP2     (INP2),
    .DSW      (DSW),
    .IS_MOTOS (IS_MOTOS)
  );

  always #5 CPUCLKx2 = ~CPUCLKx2;

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mdl[i] = 4'h0;
    credits = 0;
    prevIn2 = 3'b000;
  endtask

  // One frame of the chip as the CPU sees it, from the rules in plain arithmetic.
  task automatic modelFrame(input logic [11:0] inp, input logic [2:0] in2, input logic [23:0] dsw);
    bit coinR, s2R, s1R;
    int flags;
    coinR   = in2[2] && !prevIn2[2];
    s2R     = in2[1] && !prevIn2[1];
    s1R     = in2[0] && !prevIn2[0];
    flags   = 0;
    prevIn2 = in2;
    if (CREDIT_EN && mdl[8] == 4'h1) begin
      if (coinR && credits < MAXC) credits = credits + 1;
      if (s1R) begin
        if (credits >= 1) begin credits = credits - 1; flags = 1; end
      end else if (s2R && credits >= 2) begin
        credits = credits - 2; flags = 2;
      end
      mdl[0] = 4'(credits / 10);
      mdl[1] = 4'(credits % 10);
      mdl[2] = 4'(flags);
    end else if (mdl[8] == 4'h1 || mdl[8] == 4'h3) begin
      mdl[0] = {1'b0, in2};
    end
    if (mdl[8] == 4'h1 || mdl[8] == 4'h3) begin
      mdl[4] = inp[3:0];
      mdl[5] = {2'b00, inp[5:4]};
      mdl[6] = inp[9:6];
      mdl[7] = {2'b00, inp[11:10]};
    end
    if (mdl[24] != 4'h0) begin
      for (int k = 0; k < 6; k++) mdl[16 + k] = dsw[4*k +: 4];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string step);
    logic [5:0] a6;
    for (int a = 0; a < 32; a++) begin
      a6 = {1'($urandom_range(1)), 5'(a)};
      AD = a6;
      #1;
      checkOutput($sformatf("%s nib%02h", step, a), DO, {4'h0, mdl[a]});
    end
    checkOutput({step, " motos"}, {7'b0, IS_MOTOS},
                {7'b0, (mdl[8] == 4'h5) && (mdl[24] == 4'h7)});
  endtask

  task automatic cpuWrite(input logic [4:0] addr, input logic [3:0] data);
    @(negedge CPUCLKx2);
    CS = 1'b1; WE = 1'b1; AD = {1'($urandom_range(1)), addr};
    DI = {4'($urandom_range(15)), data};
    @(posedge CPUCLKx2);
    @(negedge CPUCLKx2);
    CS = 1'b0; WE = 1'b0;
    mdl[addr] = data;
  endtask

  task automatic applyStimulus(input logic [11:0] inp, input logic [2:0] in2,
                               input logic [23:0] dsw, input bit hold);
    @(negedge CPUCLKx2);
    INP = inp; INP2 = in2; DSW = dsw; IO_HOLD = hold; VBLANK = 1'b1;
    repeat (6) @(posedge CPUCLKx2);
    @(negedge CPUCLKx2);
    VBLANK = 1'b0;
    @(posedge CPUCLKx2);
    @(negedge CPUCLKx2);
    IO_HOLD = 1'b0;
    if (!hold) modelFrame(inp, in2, dsw);
  endtask

  initial begin
    logic [11:0] rInp;
    logic [23:0] rDsw;
    logic [2:0]  rIn2;
    logic [3:0]  modes [4];
    modes = '{4'h0, 4'h1, 4'h3, 4'h5};
    RESET_N = 1'b0; VBLANK = 1'b0; IO_HOLD = 1'b0; CS = 1'b0; WE = 1'b0;
    AD = '0; DI = '0; INP = '0; INP2 = '0; DSW = '0;
    modelReset();
    repeat (3) @(posedge CPUCLKx2);
    @(negedge CPUCLKx2);
    checkAll("reset");
    RESET_N = 1'b1;

    cpuWrite(5'h08, 4'h1);
    for (int i = 0; i < 5; i++) applyStimulus(12'($urandom), (i % 2 == 0) ? 3'b100 : 3'b000, 24'($urandom), 1'b0);
    checkAll("coin3");
    applyStimulus(12'($urandom), 3'b010, 24'($urandom), 1'b0);
    checkAll("start2");
    applyStimulus(12'($urandom), 3'b000, 24'($urandom), 1'b0);

    for (int i = 0; i < 100; i++) begin
      applyStimulus(12'($urandom), 3'b100, 24'($urandom), 1'b0);
      applyStimulus(12'($urandom), 3'b000, 24'($urandom), 1'b0);
    end
    checkAll("sat99");
    for (int i = 0; i < 49; i++) begin
      applyStimulus(12'($urandom), 3'b010, 24'($urandom), 1'b0);
      applyStimulus(12'($urandom), 3'b000, 24'($urandom), 1'b0);
    end
    checkAll("credit1");
    applyStimulus(12'($urandom), 3'b011, 24'($urandom), 1'b0);
    checkAll("s1wins");

    cpuWrite(5'h18, 4'h1);
    applyStimulus(12'($urandom), 3'b000, 24'hA5C3F0, 1'b0);
    checkAll("dsw");

    cpuWrite(5'h08, 4'h5);
    cpuWrite(5'h18, 4'h7);
    checkOutput("motos_on", {7'b0, IS_MOTOS}, 8'h01);
    cpuWrite(5'h18, 4'h0);
    checkOutput("motos_off", {7'b0, IS_MOTOS}, 8'h00);

    cpuWrite(5'h08, 4'h1);
    cpuWrite(5'h18, 4'h1);
    applyStimulus(12'($urandom), 3'b100, 24'($urandom), 1'b1);
    checkAll("hold");

    // CPU write lands in the FORMAT cycle (third clock after the VBLANK edge).
    rInp = 12'($urandom); rDsw = 24'($urandom);
    @(negedge CPUCLKx2);
    INP = rInp; INP2 = 3'b100; DSW = rDsw; VBLANK = 1'b1;
    repeat (3) @(posedge CPUCLKx2);
    @(negedge CPUCLKx2);
    CS = 1'b1; WE = 1'b1; AD = 6'h00; DI = 8'h09;
    @(posedge CPUCLKx2);
    @(negedge CPUCLKx2);
    CS = 1'b0; WE = 1'b0;
    repeat (2) @(posedge CPUCLKx2);
    @(negedge CPUCLKx2);
    VBLANK = 1'b0;
    @(posedge CPUCLKx2);
    @(negedge CPUCLKx2);
    modelFrame(rInp, 3'b100, rDsw);
    mdl[0] = 4'h9;
    checkAll("collide");

    for (int i = 0; i < 20; i++) begin
      cpuWrite(5'h08, modes[$urandom_range(3)]);
      cpuWrite(5'h18, (i % 4 == 0) ? 4'h7 : 4'($urandom_range(15)));
      rIn2 = 3'($urandom);
      applyStimulus(12'($urandom), rIn2, 24'($urandom), 1'b0);
      checkAll($sformatf("rand%0d", i));
    end

    cpuWrite(5'h08, 4'h1);
    @(negedge CPUCLKx2);
    INP = 12'hFFF; INP2 = 3'b111; DSW = 24'hFFFFFF; VBLANK = 1'b1;
    repeat (2) @(posedge CPUCLKx2);
    @(negedge CPUCLKx2);
    RESET_N = 1'b0;
    VBLANK  = 1'b0;
    modelReset();
    checkAll("midreset");
    repeat (4) @(posedge CPUCLKx2);
    @(negedge CPUCLKx2);
    RESET_N = 1'b1;
    repeat (4) @(posedge CPUCLKx2);
    @(negedge CPUCLKx2);
    checkAll("postreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
